// File: rtl/calc_mc_if.sv
// Request/response bundle for the calc_mc arithmetic unit.
// The master drives requests and out_ready; the slave returns results and flags.
interface calc_mc_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       code;
  logic [3:0]       flags;

  modport master (
    output in_valid, op, a, b, shamt, out_ready,
    input  in_ready, out_valid, result, code, flags
  );

  modport slave (
    input  in_valid, op, a, b, shamt, out_ready,
    output in_ready, out_valid, result, code, flags
  );
endinterface

// File: rtl/calc_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, WIDTH-cycle shift-add multiply,
// valid/ready result handshake and a persistent {S,Z,C,V} flag register.
module calc_mc #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst,
  calc_mc_if.slave bus
);

  localparam logic [3:0] OP_MUL = 4'd6;

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [3:0]       code;
    logic             ld;
  } alu_t;

  function automatic alu_t alu(input logic [3:0] op_i, input logic [WIDTH-1:0] a_i,
                               input logic [WIDTH-1:0] b_i, input logic [SHW-1:0] sh_i);
    alu_t         r;
    logic [WIDTH:0] x;
    logic         c;
    logic         v;
    int           n;
    r = '0;
    x = '0;
    c = 1'b0;
    v = 1'b0;
    n = int'(sh_i);
    r.ld = 1'b1;
    case (op_i)
      4'd0: begin
        x = {1'b0, a_i} + {1'b0, b_i};
        r.res = x[WIDTH-1:0];
        c = x[WIDTH];
        v = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (x[WIDTH-1] != a_i[WIDTH-1]);
      end
      4'd1, 4'd5: begin
        x = {1'b0, b_i} - {1'b0, a_i};
        r.res = x[WIDTH-1:0];
        c = x[WIDTH];
        v = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (x[WIDTH-1] != b_i[WIDTH-1]);
      end
      4'd2:  r.res = a_i & b_i;
      4'd3:  r.res = a_i | b_i;
      4'd4:  r.res = a_i ^ b_i;
      4'd8: begin
        r.res = b_i << sh_i;
        if (n != 0) c = b_i[WIDTH-n];
      end
      4'd9: begin
        // Rotate left; the n==0 guard avoids a full-width right shift term
        if (n != 0) r.res = (b_i << sh_i) | (b_i >> (WIDTH - n));
        else        r.res = b_i;
      end
      4'd10: begin
        r.res = b_i >> sh_i;
        if (n != 0) c = b_i[n-1];
      end
      4'd11: begin
        r.res = WIDTH'($signed(b_i) >>> sh_i);
        if (n != 0) c = b_i[n-1];
      end
      4'd12: r.res = b_i;
      4'd13: begin
        r.res = a_i;
        r.ld  = 1'b0;
      end
      default: r.ld = 1'b0;
    endcase
    if (r.ld) r.code = {r.res[WIDTH-1], (r.res == '0), c, v};
    return r;
  endfunction

  state_t               state, state_n;
  logic                 accept;
  logic                 last;
  alu_t                 alu_r;
  logic [2*WIDTH-1:0]   acc_p0, mcand_p0, acc_n;
  logic [WIDTH-1:0]     mplier_p0;
  logic [SHW-1:0]       cnt_p0;
  logic [3:0]           mul_code;
  logic [WIDTH-1:0]     result_p1;
  logic [3:0]           code_p1;
  logic [3:0]           flags_p1;
  logic                 vld_p1;

  // Output stalls are handled in IDLE through in_ready, so a request can be
  // accepted on the same cycle the consumer releases the held result.
  assign bus.in_ready  = !rst && (state == IDLE) && (!vld_p1 || bus.out_ready);
  assign bus.out_valid = vld_p1;
  assign bus.result    = result_p1;
  assign bus.code      = code_p1;
  assign bus.flags     = flags_p1;

  assign accept = bus.in_valid && bus.in_ready;
  assign last   = (cnt_p0 == SHW'(WIDTH - 1));

  always_comb begin
    alu_r    = alu(bus.op, bus.a, bus.b, bus.shamt);
    acc_n    = mplier_p0[0] ? (acc_p0 + mcand_p0) : acc_p0;
    mul_code = {acc_n[WIDTH-1], (acc_n[WIDTH-1:0] == '0), (|acc_n[2*WIDTH-1:WIDTH]), 1'b0};
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept && (bus.op == OP_MUL)) state_n = MUL;
      MUL:     if (last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Stage p0: multiply iterations; stage p1: registered result/code/flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vld_p1    <= 1'b0;
      result_p1 <= '0;
      code_p1   <= '0;
      flags_p1  <= '0;
      acc_p0    <= '0;
      mcand_p0  <= '0;
      mplier_p0 <= '0;
      cnt_p0    <= '0;
    end else begin
      state <= state_n;
      if (bus.out_ready) vld_p1 <= 1'b0;
      if (accept) begin
        if (bus.op == OP_MUL) begin
          acc_p0    <= '0;
          mcand_p0  <= {{WIDTH{1'b0}}, bus.a};
          mplier_p0 <= bus.b;
          cnt_p0    <= '0;
        end else begin
          result_p1 <= alu_r.res;
          code_p1   <= alu_r.code;
          vld_p1    <= 1'b1;
          if (alu_r.ld) flags_p1 <= alu_r.code;
        end
      end
      if (state == MUL) begin
        acc_p0    <= acc_n;
        mcand_p0  <= mcand_p0 << 1;
        mplier_p0 <= mplier_p0 >> 1;
        cnt_p0    <= cnt_p0 + 1'b1;
        if (last) begin
          result_p1 <= acc_n[WIDTH-1:0];
          code_p1   <= mul_code;
          flags_p1  <= mul_code;
          vld_p1    <= 1'b1;
        end
      end
    end
  end

endmodule
